// File: rtl/serial_pattern_pkg.sv
// Shared encodings and power-up constants for the serial pattern detector.
// Default pattern and mask are all ones, so a fresh detector finds runs of ones.
package serial_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_FRAMED     = 2'b00,
        MODE_OVERLAP    = 2'b01,
        MODE_NONOVERLAP = 2'b10
    } mode_t;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    localparam int          MAX_WIDTH       = 16;
    localparam logic [15:0] DEFAULT_PATTERN = 16'hFFFF;
    localparam logic [15:0] DEFAULT_MASK    = 16'hFFFF;

    // The reserved encoding 2'b11 behaves as framed.
    function automatic mode_t decode_mode(input logic [1:0] mode_bits);
        case (mode_bits)
            2'b01:   return MODE_OVERLAP;
            2'b10:   return MODE_NONOVERLAP;
            default: return MODE_FRAMED;
        endcase
    endfunction

endpackage

// File: rtl/serial_pattern_detector_sat_counter.sv
// Saturating event counter; a clear coinciding with an increment loads 1
// so the event that arrives with the clear is not lost.
module sat_counter #(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   inc,
    input  logic                   clear,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   sat
);

    logic [COUNT_WIDTH-1:0] count_reg;
    logic [COUNT_WIDTH-1:0] count_next;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = inc ? COUNT_WIDTH'(1) : '0;
        end else if (inc && !sat) begin
            count_next = count_reg + COUNT_WIDTH'(1);
        end
    end

    assign sat   = &count_reg;
    assign count = count_reg;

endmodule

// File: rtl/serial_pattern_detector.sv
// Serial bit-pattern detector with programmable pattern/mask and framed,
// sliding-overlap or sliding-non-overlap matching; one-cycle registered match pulse.
module serial_pattern_detector
    import serial_pattern_pkg::*;
#(
    parameter int WIDTH       = 3,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Data_In,
    input  logic                   Data_Valid,
    input  logic                   Load,
    input  logic [WIDTH-1:0]       Pattern_In,
    input  logic [WIDTH-1:0]       Mask_In,
    input  logic [1:0]             Mode,
    input  logic                   Clear_Count,
    output logic                   Data_Out,
    output logic [COUNT_WIDTH-1:0] Match_Count,
    output logic                   Count_Sat,
    output logic                   Filled
);

    localparam int               FILL_W    = $clog2(WIDTH + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);

    logic [WIDTH-1:0]  pattern_reg, pattern_next;
    logic [WIDTH-1:0]  mask_reg, mask_next;
    mode_t             mode_reg, mode_next;
    logic [WIDTH-1:0]  shift_reg, shift_next;
    logic [FILL_W-1:0] fill_reg, fill_next;
    state_t            state_reg, state_next;
    logic              data_out_reg, data_out_next;

    logic [WIDTH-1:0]  window;
    logic [WIDTH-1:0]  bit_miss;
    logic              complete;
    logic              hit;

    // Window includes the bit being sampled this cycle, newest in the LSB.
    assign window = {shift_reg[WIDTH-2:0], Data_In};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cmp
            assign bit_miss[gi] = (window[gi] ^ pattern_reg[gi]) & mask_reg[gi];
        end
    endgenerate

    assign complete = Data_Valid && !Load &&
                      ((state_reg == ST_FULL) || (fill_reg == FILL_LAST));
    assign hit      = complete && !(|bit_miss);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            pattern_reg  <= DEFAULT_PATTERN[WIDTH-1:0];
            mask_reg     <= DEFAULT_MASK[WIDTH-1:0];
            mode_reg     <= MODE_FRAMED;
            shift_reg    <= '0;
            fill_reg     <= '0;
            state_reg    <= ST_FILL;
            data_out_reg <= 1'b0;
        end else begin
            pattern_reg  <= pattern_next;
            mask_reg     <= mask_next;
            mode_reg     <= mode_next;
            shift_reg    <= shift_next;
            fill_reg     <= fill_next;
            state_reg    <= state_next;
            data_out_reg <= data_out_next;
        end
    end

    always_comb begin
        pattern_next  = pattern_reg;
        mask_next     = mask_reg;
        mode_next     = mode_reg;
        shift_next    = shift_reg;
        fill_next     = fill_reg;
        state_next    = state_reg;
        data_out_next = 1'b0;
        if (Load) begin
            pattern_next = Pattern_In;
            mask_next    = Mask_In;
            mode_next    = decode_mode(Mode);
            shift_next   = '0;
            fill_next    = '0;
            state_next   = ST_FILL;
        end else if (Data_Valid) begin
            shift_next    = window;
            data_out_next = hit;
            case (state_reg)
                ST_FILL: begin
                    if (fill_reg == FILL_LAST) begin
                        // Framed always restarts; non-overlap restarts only after a hit.
                        if (mode_reg == MODE_FRAMED ||
                            (mode_reg == MODE_NONOVERLAP && hit)) begin
                            fill_next  = '0;
                            state_next = ST_FILL;
                        end else begin
                            fill_next  = FILL_FULL;
                            state_next = ST_FULL;
                        end
                    end else begin
                        fill_next = fill_reg + FILL_W'(1);
                    end
                end
                ST_FULL: begin
                    if (mode_reg == MODE_FRAMED ||
                        (mode_reg == MODE_NONOVERLAP && hit)) begin
                        fill_next  = '0;
                        state_next = ST_FILL;
                    end
                end
                default: begin
                    fill_next  = '0;
                    state_next = ST_FILL;
                end
            endcase
        end
    end

    always_comb begin
        Filled   = (state_reg == ST_FULL);
        Data_Out = data_out_reg;
    end

    sat_counter #(
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_count (
        .Clock (Clock),
        .Reset (Reset),
        .inc   (hit),
        .clear (Clear_Count),
        .count (Match_Count),
        .sat   (Count_Sat)
    );

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed bench: a default-sized detector plus a 2-bit-counter copy on the
// same stimulus, checked with immediate assertions after each sampling edge.
module tb_serial_pattern_detector;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Data_In, Data_Valid, Load, Clear_Count;
    logic [2:0] Pattern_In, Mask_In;
    logic [1:0] Mode;

    logic       a_out, a_sat, a_filled;
    logic [7:0] a_count;
    logic       b_out, b_sat, b_filled;
    logic [1:0] b_count;

    int vectors = 0;
    int fails   = 0;

    always #5 Clock = ~Clock;

    serial_pattern_detector #(.WIDTH(3), .COUNT_WIDTH(8)) dut_a (
        .Clock(Clock), .Reset(Reset), .Data_In(Data_In), .Data_Valid(Data_Valid),
        .Load(Load), .Pattern_In(Pattern_In), .Mask_In(Mask_In), .Mode(Mode),
        .Clear_Count(Clear_Count), .Data_Out(a_out), .Match_Count(a_count),
        .Count_Sat(a_sat), .Filled(a_filled)
    );

    serial_pattern_detector #(.WIDTH(3), .COUNT_WIDTH(2)) dut_b (
        .Clock(Clock), .Reset(Reset), .Data_In(Data_In), .Data_Valid(Data_Valid),
        .Load(Load), .Pattern_In(Pattern_In), .Mask_In(Mask_In), .Mode(Mode),
        .Clear_Count(Clear_Count), .Data_Out(b_out), .Match_Count(b_count),
        .Count_Sat(b_sat), .Filled(b_filled)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic d, input logic ld, input logic clr);
        @(negedge Clock);
        Data_Valid  = v;
        Data_In     = d;
        Load        = ld;
        Clear_Count = clr;
        @(posedge Clock);
        #1;
        Data_Valid  = 1'b0;
        Load        = 1'b0;
        Clear_Count = 1'b0;
    endtask

    initial begin
        Reset = 1'b0; Data_In = 1'b0; Data_Valid = 1'b0; Load = 1'b0; Clear_Count = 1'b0;
        Pattern_In = 3'b000; Mask_In = 3'b000; Mode = 2'b00;
        repeat (2) @(posedge Clock);
        #1;
        check("rst_dout", a_out, 0);
        check("rst_count", a_count, 0);
        check("rst_sat", a_sat, 0);
        check("rst_filled", a_filled, 0);
        @(negedge Clock); Reset = 1'b1;

        // Defaults: framed 111; bits 1,1,1,0,1,1
        step(1, 1, 0, 0); check("t1_b1", a_out, 0);
        step(1, 1, 0, 0); check("t1_b2", a_out, 0);
        step(1, 1, 0, 0); check("t1_b3", a_out, 1); check("t1_cnt3", a_count, 1);
        check("t1_filled", a_filled, 0);
        step(1, 0, 0, 0); check("t1_b4", a_out, 0);
        step(1, 1, 0, 0); check("t1_b5", a_out, 0);
        step(1, 1, 0, 0); check("t1_b6", a_out, 0); check("t1_cnt", a_count, 1);

        // Clear alone, then overlap 101
        step(0, 0, 0, 1); check("clr_alone", a_count, 0);
        Pattern_In = 3'b101; Mask_In = 3'b111; Mode = 2'b01;
        step(0, 0, 1, 0); check("t2_load_dout", a_out, 0);
        Pattern_In = 3'b000; Mask_In = 3'b000; Mode = 2'b10;
        step(1, 1, 0, 0); check("t2_b1", a_out, 0);
        step(1, 0, 0, 0); check("t2_b2", a_out, 0); check("t2_fill2", a_filled, 0);
        step(1, 1, 0, 0); check("t2_b3", a_out, 1); check("t2_full", a_filled, 1);
        step(1, 0, 0, 0); check("t2_b4", a_out, 0);
        step(1, 1, 0, 0); check("t2_b5", a_out, 1); check("t2_cnt", a_count, 2);
        check("t2_bcnt", b_count, 2);

        // Non-overlap 101, clear with the load
        Pattern_In = 3'b101; Mask_In = 3'b111; Mode = 2'b10;
        step(0, 0, 1, 1); check("t3_clr", a_count, 0);
        step(1, 1, 0, 0); check("t3_b1", a_out, 0);
        step(1, 0, 0, 0); check("t3_b2", a_out, 0);
        step(1, 1, 0, 0); check("t3_b3", a_out, 1); check("t3_refill", a_filled, 0);
        step(1, 0, 0, 0); check("t3_b4", a_out, 0);
        step(1, 1, 0, 0); check("t3_b5", a_out, 0); check("t3_cnt", a_count, 1);

        // Masked 10x, overlap, gaps with Data_In held high
        Pattern_In = 3'b100; Mask_In = 3'b110; Mode = 2'b01;
        step(0, 0, 1, 1);
        step(1, 1, 0, 0); step(1, 0, 0, 0);
        step(1, 0, 0, 0); check("t4_w100", a_out, 1);
        step(0, 1, 0, 0); check("t4_gap1", a_out, 0); check("t4_gapfull", a_filled, 1);
        step(0, 1, 0, 0); check("t4_gap2", a_out, 0); check("t4_gapcnt", a_count, 1);
        step(1, 1, 0, 0); check("t4_w001", a_out, 0);
        step(1, 0, 0, 0); check("t4_w010", a_out, 0);
        step(1, 1, 0, 0); check("t4_w101", a_out, 1); check("t4_cnt", a_count, 2);

        // Mask zero: every window hits; saturate the 2-bit counter
        Pattern_In = 3'b111; Mask_In = 3'b000; Mode = 2'b01;
        step(0, 0, 1, 1);
        step(1, 0, 0, 0); check("t5_b1", a_out, 0);
        step(1, 0, 0, 0); check("t5_b2", a_out, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0);
            check($sformatf("t5_pulse%0d", i + 1), b_out, 1);
            if (i == 2) check("t5_bcnt3", b_count, 3);
        end
        check("t5_acnt", a_count, 5);
        check("t5_bsatcnt", b_count, 3);
        check("t5_bsat", b_sat, 1);
        check("t5_asat", a_sat, 0);
        step(1, 0, 0, 1); check("t5_clrhit_dout", b_out, 1);
        check("t5_clrhit_a", a_count, 1); check("t5_clrhit_b", b_count, 1);
        check("t5_clrhit_bsat", b_sat, 0);

        // Async reset mid-frame discards config and partial frame
        Pattern_In = 3'b000; Mask_In = 3'b111; Mode = 2'b00;
        step(0, 0, 1, 0);
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        #2; Reset = 1'b0; #1;
        check("t6_async_cnt", a_count, 0);
        check("t6_async_bcnt", b_count, 0);
        check("t6_async_dout", a_out, 0);
        @(posedge Clock); @(negedge Clock); Reset = 1'b1;
        step(1, 1, 0, 0); check("t6_b1", a_out, 0);
        step(1, 1, 0, 0); check("t6_b2", a_out, 0);
        step(1, 1, 0, 0); check("t6_b3", a_out, 1); check("t6_cnt", a_count, 1);

        // Load with a valid bit: bit dropped; reserved mode acts framed
        Pattern_In = 3'b111; Mask_In = 3'b111; Mode = 2'b11;
        step(1, 1, 1, 0); check("t7_load_dout", a_out, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0); check("t7_b2", a_out, 0);
        step(1, 1, 0, 0); check("t7_b3", a_out, 1); check("t7_framed", a_filled, 0);
        check("t7_cnt", a_count, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/serial_pattern_detector.md
# serial_pattern_detector

Parametrised serial bit-pattern detector for single-bit serial inputs, with a programmable pattern and don't-care mask. It supports framed, sliding-overlap and sliding-non-overlap matching, plus a saturating match counter. It sits directly on a sampled serial line and emits a one-cycle match pulse to downstream control logic. After reset it detects WIDTH consecutive ones in fixed frames, so it can replace the existing fixed 3-bit detector.

## Interface
- WIDTH, 3, pattern length in bits; legal range 2..16.
- COUNT_WIDTH, 8, width of match counter.
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- Data_In  input  1  serial data bit; sampled only when Data_Valid=1.
- Data_Valid  input  1  qualifies Data_In on this edge.
- Load  input  1  latches Pattern_In, Mask_In and Mode; restarts matching.
- Pattern_In  input  WIDTH  pattern; bit WIDTH-1 = first bit received.
- Mask_In  input  WIDTH  1 = compare bit, 0 = don't care.
- Mode  input  2  00 framed, 01 sliding overlap, 10 sliding non-overlap, 11 reserved (treated as 00).
- Clear_Count  input  1  synchronous clear of Match_Count.
- Data_Out  output  1  registered one-cycle match pulse.
- Match_Count  output  COUNT_WIDTH  number of matches, saturating.
- Count_Sat  output  1  high while Match_Count is all ones.
- Filled  output  1  high when the window holds WIDTH valid bits (state FULL).

## Operation
- Reset values:
  - pattern reg all ones; mask reg all ones; mode reg framed.
  - shift reg 0; fill counter 0; state FILL.
  - Data_Out 0; Match_Count 0; Count_Sat 0; Filled 0.
- Shift reg on a valid bit: `shift <= {shift[WIDTH-2:0], Data_In}`. The newest bit is the LSB.
- Candidate window = the shift value after including the current bit.
- Hit = `((window ^ pattern) & mask) == 0`, qualified by the fill counter reaching WIDTH with this bit.
  - Mask all zero: every completed window is a hit.
- States: FILL (fewer than WIDTH bits collected since restart) and FULL.
- Framed mode:
  - A hit is evaluated only when the WIDTH-th bit of a frame arrives.
  - Fill counter then returns to 0 and the state to FILL, whether or not the frame hit.
  - FULL is never held across cycles.
- Sliding overlap:
  - FILL→FULL when the WIDTH-th bit arrives.
  - In FULL, every valid bit evaluates a hit; the state stays FULL.
- Sliding non-overlap:
  - Same as sliding overlap, but a hit returns the state to FILL with the fill counter at 0.
  - A non-hit stays in FULL.
- Load:
  - Captures pattern, mask and mode (11→00).
  - Clears the shift reg and fill counter; state FILL.
  - Match_Count is unchanged.
  - Load with Data_Valid in the same cycle: Load wins and the bit is dropped.
- Mode, pattern and mask inputs are ignored except on Load.
- Counter:
  - Increments on each hit, saturating at 2^COUNT_WIDTH-1; Count_Sat is combinational from the count.
  - Clear_Count alone → 0.
  - Clear_Count with a hit in the same cycle → 1.
  - Data_Out still pulses when the count is saturated.
- Data_Valid=0: no state, shift or counter change; Data_Out 0.

## Timing
- Data_Out is asserted for exactly one cycle, on the cycle following the edge that sampled the completing bit (latency 1).
- Match_Count updates on that same edge.
- Back-to-back hits in overlap mode give Data_Out high on consecutive cycles.
- Filled updates on the sampling edge.
- Asynchronous reset mid-frame:
  - All outputs go to reset values immediately; the partial frame is discarded.
  - The programmed pattern reverts to the defaults.
- Throughput: one bit per cycle; no backpressure.

## Structure
- Package serial_pattern_pkg holds:
  - mode encodings MODE_FRAMED, MODE_OVERLAP, MODE_NONOVERLAP;
  - state encodings ST_FILL, ST_FULL;
  - default pattern/mask constants.
- Sub-module sat_counter (parameter COUNT_WIDTH): inc/clear inputs, count and sat outputs, clear+inc → 1.
- The top level contains the configuration registers, shift reg, fill counter, FSM and compare logic.

## Test plan
- Reset, WIDTH=3 defaults, framed, bits 1,1,1,0,1,1 → one Data_Out pulse the cycle after the 3rd bit; Match_Count=1.
- Load pattern 3'b101, mask 3'b111, overlap; bits 1,0,1,0,1 → pulses after bits 3 and 5; Match_Count=2.
- Same pattern, non-overlap; bits 1,0,1,0,1 → one pulse only, after bit 3.
- Pattern 3'b100 with mask 3'b110; windows 100 and 101 → both hit. Data_Valid low gaps inserted → no shift and no spurious pulse.
- COUNT_WIDTH=2; force 5 hits → Match_Count=3, Count_Sat=1, 5 pulses. Clear_Count coincident with a hit → Match_Count=1.
- Async reset asserted after 2 bits of a framed frame, then release and send 1,1,1 → exactly one pulse, after the 3rd new bit. Load with Data_Valid in the same cycle → that bit is not counted.
